// File: rtl/xlr8_spi_burst_pkg.sv
// xlr8_spi_burst_pkg: register map, bit positions, register layouts and FSM state encoding for the SPI burst buffer
package xlr8_spi_burst_pkg;
   localparam logic [5:0] BCR1_ADDR = 6'h1A;
   localparam logic [5:0] BSR1_ADDR = 6'h1B;
   localparam logic [5:0] BDR1_ADDR = 6'h1C;
   localparam int BCR_EN   = 0;
   localparam int BCR_IE   = 1;
   localparam int BCR_CLR  = 7;
   localparam int BSR_TXE  = 0;
   localparam int BSR_TXF  = 1;
   localparam int BSR_RXE  = 2;
   localparam int BSR_RXF  = 3;
   localparam int BSR_DONE = 4;
   localparam int BSR_WCOL = 5;
   typedef struct packed {
      logic       clr;
      logic [4:0] rsv;
      logic       ie;
      logic       en;
   } bcr_t;
   typedef struct packed {
      logic [1:0] rsv;
      logic       wcol;
      logic       done;
      logic       rx_full;
      logic       rx_empty;
      logic       tx_full;
      logic       tx_empty;
   } bsr_t;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPT} burst_state_t;
endpackage

// File: rtl/xlr8_spi_burst_if.sv
// xlr8_spi_burst_if: AVR I/O bus, SPI data-register handshake and interrupt signals of the burst buffer
//   slave  = burst block side, master = core/SPI side
interface xlr8_spi_burst_if;
   logic       clken;
   logic [5:0] adr;
   logic [7:0] dbus_in;
   logic       iore;
   logic       iowe;
   logic [7:0] dbus_out;
   logic       out_en;
   logic       spi_wr;
   logic [7:0] spi_wdata;
   logic       spi_done;
   logic [7:0] spi_rdata;
   logic       spi_busy;
   logic       burst_irq;
   logic       burst_ack;
   modport slave (
      input  clken, adr, dbus_in, iore, iowe, spi_done, spi_rdata, burst_ack,
      output dbus_out, out_en, spi_wr, spi_wdata, spi_busy, burst_irq
   );
   modport master (
      output clken, adr, dbus_in, iore, iowe, spi_done, spi_rdata, burst_ack,
      input  dbus_out, out_en, spi_wr, spi_wdata, spi_busy, burst_irq
   );
endinterface

// File: rtl/xlr8_spi_burst_fifo.sv
// xlr8_spi_burst_fifo: 8-bit synchronous FIFO with flush
//   clk/rst: clock, sync active-high reset; i_push/i_din: write; i_pop/o_dout: read head (show-ahead)
//   i_flush: empty in one cycle (beats a same-cycle push); o_full/o_empty: status
module xlr8_spi_burst_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [7:0] i_din,
   output logic [7:0] o_dout,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] r_mem [DEPTH];
   logic [AW:0] r_wptr, r_rptr, w_count;
   logic w_push, w_pop;
   assign w_count = r_wptr - r_rptr;
   assign o_empty = w_count == '0;
   assign o_full  = w_count[AW];
   assign w_pop   = i_pop & !o_empty;
   // a push into a full FIFO is only legal when the head leaves in the same cycle
   assign w_push  = i_push & (!o_full | w_pop);
   assign o_dout  = r_mem[r_rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/xlr8_spi_burst.sv
// xlr8_spi_burst: TX/RX burst buffer feeding the AVR SPI data register with one interrupt per burst
//   clk/rst: clock, sync active-high reset; bus: I/O regs BCR/BSR/BDR, SPDR load/capture handshake, burst irq/ack
module xlr8_spi_burst
   import xlr8_spi_burst_pkg::*;
#(
   parameter int         DEPTH    = 8,
   parameter logic [5:0] BCR_ADDR = BCR1_ADDR,
   parameter logic [5:0] BSR_ADDR = BSR1_ADDR,
   parameter logic [5:0] BDR_ADDR = BDR1_ADDR
) (
   input logic             clk,
   input logic             rst,
   xlr8_spi_burst_if.slave bus
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LOAD = LOAD;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_CAPT = CAPT;
   logic [1:0] r_state, w_nxt;
   logic r_en, r_ie, r_done, r_wcol, r_drop;
   logic w_hit_bcr, w_hit_bsr, w_hit_bdr, w_wr, w_rd, w_clr, w_ld, w_go, w_drop;
   logic w_tx_push, w_tx_full, w_tx_empty, w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   logic w_set_done, w_wcol, w_bsr_wr;
   logic [7:0] w_tx_dout, w_rx_dout;
   bcr_t w_bcr;
   bsr_t w_bsr;
   assign w_hit_bcr = bus.adr == BCR_ADDR;
   assign w_hit_bsr = bus.adr == BSR_ADDR;
   assign w_hit_bdr = bus.adr == BDR_ADDR;
   assign w_wr      = bus.iowe & bus.clken;
   assign w_rd      = bus.iore & bus.clken;
   assign w_bcr     = bus.dbus_in;
   assign w_bsr_wr  = w_wr & w_hit_bsr;
   assign w_clr     = w_wr & w_hit_bcr & w_bcr.clr;
   assign w_ld      = (r_state == S_LOAD) & bus.clken & !rst;
   assign w_tx_push = w_wr & w_hit_bdr;
   assign w_wcol    = w_tx_push & w_tx_full & !w_ld;
   assign w_rx_pop  = w_rd & w_hit_bdr;
   // a flush landing while a byte is in flight discards that byte when it completes
   assign w_drop    = r_drop | w_clr;
   assign w_rx_push = (r_state == S_WAIT) & bus.spi_done & !w_drop & bus.clken;
   assign w_go      = r_en & !w_tx_empty & !w_rx_full & !w_clr;
   assign w_set_done = (r_state == S_CAPT) & w_tx_empty & !w_clr;
   assign w_bsr     = {2'b00, r_wcol, r_done, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
   // CAPT shares the IDLE launch condition; an empty TX there means the burst is complete
   assign w_nxt = (r_state == S_WAIT) ? (!bus.spi_done ? S_WAIT : w_drop ? S_IDLE : S_CAPT) :
                  (r_state == S_LOAD) ? S_WAIT :
                  w_go ? S_LOAD : S_IDLE;
   xlr8_spi_burst_fifo #(.DEPTH(DEPTH)) u_txf (
      .clk(clk), .rst(rst), .i_push(w_tx_push), .i_pop(w_ld), .i_flush(w_clr),
      .i_din(bus.dbus_in), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
   );
   xlr8_spi_burst_fifo #(.DEPTH(DEPTH)) u_rxf (
      .clk(clk), .rst(rst), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_flush(w_clr),
      .i_din(bus.spi_rdata), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
         r_ie    <= 1'b0;
         r_done  <= 1'b0;
         r_wcol  <= 1'b0;
         r_drop  <= 1'b0;
      end else if (bus.clken) begin
         r_state <= w_nxt;
         if (w_wr && w_hit_bcr) begin
            r_en <= w_bcr.en;
            r_ie <= w_bcr.ie;
         end
         r_done <= w_set_done | (r_done & !bus.burst_ack & !(w_bsr_wr & bus.dbus_in[BSR_DONE]));
         r_wcol <= w_wcol | (r_wcol & !(w_bsr_wr & bus.dbus_in[BSR_WCOL]));
         r_drop <= (r_state == S_WAIT) & !bus.spi_done & w_drop;
      end
   end
   assign bus.out_en    = !rst & bus.iore & (w_hit_bcr | w_hit_bsr | w_hit_bdr);
   assign bus.dbus_out  = !bus.out_en ? 8'h00 :
                          w_hit_bcr ? {6'd0, r_ie, r_en} :
                          w_hit_bsr ? w_bsr :
                          w_rx_empty ? 8'h00 : w_rx_dout;
   assign bus.spi_wr    = w_ld;
   assign bus.spi_wdata = w_ld ? w_tx_dout : 8'h00;
   assign bus.spi_busy  = r_state != S_IDLE;
   assign bus.burst_irq = r_done & r_ie;
endmodule

// File: tb/tb_xlr8_spi_burst.sv
// tb_xlr8_spi_burst: directed self-checking bench for the SPI burst buffer with an echoing SPI responder
module tb_xlr8_spi_burst;
   import xlr8_spi_burst_pkg::*;
   localparam int DEPTH = 8;
   localparam logic [5:0] A_BCR = BCR1_ADDR;
   localparam logic [5:0] A_BSR = BSR1_ADDR;
   localparam logic [5:0] A_BDR = BDR1_ADDR;
   logic clk = 1'b0;
   logic rst = 1'b1;
   xlr8_spi_burst_if ifc();
   xlr8_spi_burst #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;
   int dly = 0;
   int base;
   logic resp_en = 1'b1;
   logic man_done = 1'b0;
   logic [7:0] pend = 8'h00;
   logic [7:0] man_rdata = 8'h00;
   logic [7:0] v;
   logic [7:0] e;
   // responder: returns ~wdata about ten cycles after each SPDR load
   assign ifc.spi_done  = (resp_en && dly == 1) || man_done;
   assign ifc.spi_rdata = resp_en ? pend : man_rdata;
   always @(posedge clk) begin
      if (rst) dly <= 0;
      else if (ifc.spi_wr) begin
         wr_cnt <= wr_cnt + 1;
         pend   <= ~ifc.spi_wdata;
         dly    <= 10;
      end else if (dly != 0) dly <= dly - 1;
   end
   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      ifc.adr = a; ifc.dbus_in = d; ifc.iowe = 1'b1;
      @(negedge clk);
      ifc.iowe = 1'b0;
   endtask
   task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
      ifc.adr = a; ifc.iore = 1'b1;
      #1 d = ifc.dbus_out;
      @(negedge clk);
      ifc.iore = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_wr(input int tgt);
      for (int i = 0; i < 400 && wr_cnt < tgt; i++) @(negedge clk);
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 100 && ifc.spi_busy; i++) @(negedge clk);
   endtask
   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      n_cmp++; if (ifc.out_en !== 1'b0) begin n_bad++; $display("FAIL rst_out_en got=%b exp=0", ifc.out_en); end
      n_cmp++; if (ifc.spi_wr !== 1'b0) begin n_bad++; $display("FAIL rst_spi_wr got=%b exp=0", ifc.spi_wr); end
      n_cmp++; if (ifc.spi_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_spi_wdata got=%h exp=00", ifc.spi_wdata); end
      n_cmp++; if (ifc.spi_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", ifc.spi_busy); end
      n_cmp++; if (ifc.burst_irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got=%b exp=0", ifc.burst_irq); end
      n_cmp++; if (ifc.dbus_out !== 8'h00) begin n_bad++; $display("FAIL rst_dbus got=%h exp=00", ifc.dbus_out); end
      rst = 1'b0;
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL rst_bsr got=%h exp=05", v); end
      io_rd(A_BCR, v);
      n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL rst_bcr got=%h exp=00", v); end
      io_wr(A_BCR, 8'h01);
      base = wr_cnt;
      io_wr(A_BDR, 8'h11);
      wait_wr(base + 1);
      idle(3);
      n_cmp++; if (ifc.spi_busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy got=%b exp=1", ifc.spi_busy); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (ifc.spi_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", ifc.spi_busy); end
      n_cmp++; if (ifc.spi_wr !== 1'b0) begin n_bad++; $display("FAIL midrst_spi_wr got=%b exp=0", ifc.spi_wr); end
      rst = 1'b0;
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL midrst_bsr got=%h exp=05", v); end
      io_rd(A_BCR, v);
      n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL midrst_bcr got=%h exp=00", v); end
      base = wr_cnt;
      idle(20);
      n_cmp++; if (wr_cnt !== base) begin n_bad++; $display("FAIL midrst_no_wr got=%0d exp=%0d", wr_cnt, base); end
   endtask
   task automatic test_burst();
      logic [7:0] exp_rx [3];
      exp_rx = '{8'h5E, 8'h4D, 8'h3C};
      io_wr(A_BCR, 8'h03);
      base = wr_cnt;
      io_wr(A_BDR, 8'hA1);
      io_wr(A_BDR, 8'hB2);
      io_wr(A_BDR, 8'hC3);
      wait_wr(base + 3);
      wait_idle();
      n_cmp++; if (wr_cnt - base !== 3) begin n_bad++; $display("FAIL burst_wr_count got=%0d exp=3", wr_cnt - base); end
      n_cmp++; if (ifc.burst_irq !== 1'b1) begin n_bad++; $display("FAIL burst_irq got=%b exp=1", ifc.burst_irq); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL burst_bsr got=%h exp=11", v); end
      for (int i = 0; i < 3; i++) begin
         io_rd(A_BDR, v);
         n_cmp++; if (v !== exp_rx[i]) begin n_bad++; $display("FAIL burst_rx%0d got=%h exp=%h", i, v, exp_rx[i]); end
      end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h15) begin n_bad++; $display("FAIL burst_bsr_drained got=%h exp=15", v); end
      io_wr(A_BSR, 8'h10);
      n_cmp++; if (ifc.burst_irq !== 1'b0) begin n_bad++; $display("FAIL burst_irq_w1c got=%b exp=0", ifc.burst_irq); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL burst_bsr_w1c got=%h exp=05", v); end
   endtask
   task automatic test_wcol();
      io_wr(A_BCR, 8'h00);
      for (int i = 0; i <= DEPTH; i++) io_wr(A_BDR, 8'(i));
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h26) begin n_bad++; $display("FAIL wcol_bsr got=%h exp=26", v); end
      io_wr(A_BSR, 8'h20);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h06) begin n_bad++; $display("FAIL wcol_clear got=%h exp=06", v); end
      io_wr(A_BCR, 8'h80);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL wcol_clr_bsr got=%h exp=05", v); end
      io_rd(A_BCR, v);
      n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL clr_reads0 got=%h exp=00", v); end
   endtask
   task automatic test_stall();
      for (int i = 0; i < DEPTH; i++) io_wr(A_BDR, 8'h40 + 8'(i));
      base = wr_cnt;
      io_wr(A_BCR, 8'h01);
      wait_wr(base + 2);
      io_wr(A_BDR, 8'h48);
      io_wr(A_BDR, 8'h49);
      wait_wr(base + DEPTH);
      idle(30);
      n_cmp++; if (wr_cnt - base !== DEPTH) begin n_bad++; $display("FAIL stall_wr_count got=%0d exp=%0d", wr_cnt - base, DEPTH); end
      n_cmp++; if (ifc.spi_busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy got=%b exp=0", ifc.spi_busy); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL stall_bsr got=%h exp=08", v); end
      io_rd(A_BDR, v);
      n_cmp++; if (v !== 8'hBF) begin n_bad++; $display("FAIL stall_pop got=%h exp=bf", v); end
      idle(30);
      n_cmp++; if (wr_cnt - base !== DEPTH + 1) begin n_bad++; $display("FAIL stall_one_more got=%0d exp=%0d", wr_cnt - base, DEPTH + 1); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL stall_bsr2 got=%h exp=08", v); end
      io_wr(A_BCR, 8'h80);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL stall_clr got=%h exp=05", v); end
   endtask
   task automatic test_clr_wait();
      io_wr(A_BCR, 8'h03);
      base = wr_cnt;
      for (int i = 0; i < 4; i++) io_wr(A_BDR, 8'hD0 + 8'(i));
      wait_wr(base + 2);
      idle(2);
      io_wr(A_BCR, 8'h83);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL clr_flush got=%h exp=05", v); end
      n_cmp++; if (ifc.spi_busy !== 1'b1) begin n_bad++; $display("FAIL clr_still_wait got=%b exp=1", ifc.spi_busy); end
      wait_idle();
      idle(5);
      n_cmp++; if (ifc.spi_busy !== 1'b0) begin n_bad++; $display("FAIL clr_idle got=%b exp=0", ifc.spi_busy); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL clr_dropped got=%h exp=05", v); end
      n_cmp++; if (ifc.burst_irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq got=%b exp=0", ifc.burst_irq); end
      n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL clr_wr_count got=%0d exp=2", wr_cnt - base); end
   endtask
   task automatic test_back_to_back();
      io_wr(A_BCR, 8'h03);
      base = wr_cnt;
      for (int i = 0; i < DEPTH - 1; i++) io_wr(A_BDR, 8'h80 + 8'(i));
      wait_wr(base + DEPTH - 1);
      wait_idle();
      io_wr(A_BSR, 8'h10);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h01) begin n_bad++; $display("FAIL b2b_fill got=%h exp=01", v); end
      resp_en = 1'b0;
      man_rdata = 8'hEE;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h01) begin n_bad++; $display("FAIL b2b_idle_done got=%h exp=01", v); end
      io_wr(A_BDR, 8'h99);
      wait_wr(base + DEPTH);
      idle(3);
      ifc.adr = A_BDR; ifc.iore = 1'b1;
      man_rdata = 8'h77; man_done = 1'b1;
      #1 v = ifc.dbus_out;
      @(negedge clk);
      ifc.iore = 1'b0; man_done = 1'b0;
      n_cmp++; if (v !== 8'h7F) begin n_bad++; $display("FAIL b2b_pop got=%h exp=7f", v); end
      idle(2);
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL b2b_count got=%h exp=11", v); end
      n_cmp++; if (ifc.burst_irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq got=%b exp=1", ifc.burst_irq); end
      ifc.burst_ack = 1'b1;
      @(negedge clk);
      ifc.burst_ack = 1'b0;
      n_cmp++; if (ifc.burst_irq !== 1'b0) begin n_bad++; $display("FAIL b2b_ack got=%b exp=0", ifc.burst_irq); end
      for (int i = 1; i < DEPTH - 1; i++) begin
         io_rd(A_BDR, v);
         e = ~(8'h80 + 8'(i));
         n_cmp++; if (v !== e) begin n_bad++; $display("FAIL b2b_rx%0d got=%h exp=%h", i, v, e); end
      end
      io_rd(A_BDR, v);
      n_cmp++; if (v !== 8'h77) begin n_bad++; $display("FAIL b2b_captured got=%h exp=77", v); end
      io_rd(A_BDR, v);
      n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL b2b_empty_read got=%h exp=00", v); end
      io_rd(A_BSR, v);
      n_cmp++; if (v !== 8'h05) begin n_bad++; $display("FAIL b2b_final_bsr got=%h exp=05", v); end
      resp_en = 1'b1;
   endtask
   initial begin
      ifc.clken = 1'b1; ifc.adr = '0; ifc.dbus_in = '0;
      ifc.iore = 1'b0; ifc.iowe = 1'b0; ifc.burst_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_burst();
      test_wcol();
      test_stall();
      test_clr_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end
endmodule
